// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - multi-channel SPI mode-0 slave frame transmitter in the clk domain
// Define SPI_FRAME_HEADER_EN to prefix each frame with an 8-bit {4'hA, seq} header.
module spi_frame_tx #(
  parameter int DATA_W      = 16,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic [N_CH*DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   miso,
  output logic                   miso_oe,
  output logic                   frame_done,
  output logic                   underrun,
  output logic                   abort
);
  localparam int PAY_W = N_CH * DATA_W;
`ifdef SPI_FRAME_HEADER_EN
  localparam int FRAME_BITS = PAY_W + 8;
`else
  localparam int FRAME_BITS = PAY_W;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [PAY_W-1:0]      buffer, payload;
  logic                  full;
  logic [FRAME_BITS-1:0] shreg, start_word;
  logic [CNT_W-1:0]      bit_cnt;
  logic start_frame, count_en, shift_en, exit_frame;
  logic done_set, underrun_set, abort_set;
`ifdef SPI_FRAME_HEADER_EN
  logic [3:0] seq;
`endif

  // cs chain resets low so a frame needs cs seen high, then low, after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_prev;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_prev;

  assign tx_ready = ~full;

  // channel 0 is transmitted first, so it lands in the top of the shift word
  always_comb begin
    payload = '0;
    for (int k = 0; k < N_CH; k++) begin
      payload[(N_CH-1-k)*DATA_W +: DATA_W] = full ? buffer[k*DATA_W +: DATA_W] : '0;
    end
  end

`ifdef SPI_FRAME_HEADER_EN
  assign start_word = {4'hA, seq, payload};
`else
  assign start_word = payload;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    start_frame  = 1'b0;
    count_en     = 1'b0;
    shift_en     = 1'b0;
    exit_frame   = 1'b0;
    done_set     = 1'b0;
    underrun_set = 1'b0;
    abort_set    = 1'b0;
    if (cs_rise) begin
      state_next = IDLE;
      exit_frame = 1'b1;
      abort_set  = (state == SHIFT);
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            start_frame  = 1'b1;
            underrun_set = ~full;
            state_next   = SHIFT;
          end
        end
        SHIFT: begin
          shift_en = sclk_fall;
          if (sclk_rise) begin
            count_en = 1'b1;
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              done_set   = 1'b1;
              state_next = DONE;
            end
          end
        end
        DONE: shift_en = sclk_fall;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer     <= '0;
      full       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      frame_done <= done_set;
      underrun   <= underrun_set;
      abort      <= abort_set;
      // a load coinciding with an underrun start refills the buffer for the next frame
      if (tx_valid && tx_ready) begin
        buffer <= tx_data;
        full   <= 1'b1;
      end else if (start_frame) begin
        full <= 1'b0;
      end
      if (exit_frame) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        bit_cnt <= '0;
      end else if (start_frame) begin
        shreg   <= start_word;
        miso    <= start_word[FRAME_BITS-1];
        miso_oe <= 1'b1;
        bit_cnt <= '0;
      end else begin
        if (count_en) bit_cnt <= bit_cnt + CNT_W'(1);
        if (shift_en) begin
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
          miso  <= (state == SHIFT) ? shreg[FRAME_BITS-2] : 1'b0;
        end
        if (done_set) miso <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_HEADER_EN
  always_ff @(posedge clk) begin
    if (rst)              seq <= 4'd0;
    else if (start_frame) seq <= seq + 4'd1;
  end
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb/tb_spi_frame_tx.sv - scoreboard bench for spi_frame_tx with a frame-level reference model
`timescale 1ns/1ps
module tb_spi_frame_tx;
  localparam int DATA_W = 16;
  localparam int N_CH = 4;
  localparam int SYNC_STAGES = 2;
  localparam int PW = DATA_W * N_CH;
`ifdef SPI_FRAME_HEADER_EN
  localparam int FB = PW + 8;
`else
  localparam int FB = PW;
`endif
  localparam int HALF = SYNC_STAGES + 4;
  localparam int GAP = SYNC_STAGES + 6;
  localparam int EV_DONE = 0, EV_UNDER = 1, EV_ABORT = 2;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs = 1'b1;
  logic [PW-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, miso, miso_oe, frame_done, underrun, abort;

  spi_frame_tx #(.DATA_W(DATA_W), .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .miso(miso), .miso_oe(miso_oe),
    .frame_done(frame_done), .underrun(underrun), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;
    logic [FB-1:0] data;
  } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  logic [FB-1:0] cap = '0;
  logic extra_or = 1'b0;
  logic model_full = 1'b0;
  logic [PW-1:0] model_buf = '0;
  logic [3:0] model_seq = 4'd0;

  task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame start in the model: consume the buffer or underrun, build the serial word.
  task automatic model_start(input int nbits);
    ev_t e;
    logic [PW-1:0] pay;
    logic [FB-1:0] f;
    if (model_full) begin
      pay = model_buf;
      model_full = 1'b0;
    end else begin
      pay = '0;
      e.kind = EV_UNDER;
      e.data = '0;
      exp_q.push_back(e);
    end
    f = '0;
    for (int k = 0; k < N_CH; k++) f = (f << DATA_W) | FB'(pay[k*DATA_W +: DATA_W]);
`ifdef SPI_FRAME_HEADER_EN
    f = f | {4'hA, model_seq, {PW{1'b0}}};
    model_seq = model_seq + 4'd1;
`endif
    e.kind = (nbits >= FB) ? EV_DONE : EV_ABORT;
    e.data = f;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", FB'(kind), FB'(e.kind));
      if (kind == EV_DONE) chk("frame_data", cap, e.data);
      if (kind == EV_ABORT) chk("abort_miso_oe", FB'(miso_oe), '0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (underrun) mon_ev(EV_UNDER);
      if (frame_done) mon_ev(EV_DONE);
      if (abort) mon_ev(EV_ABORT);
    end
  end

  task automatic load(input logic [PW-1:0] d);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got tx_ready %b expected 1", tx_ready);
    end
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    model_full = 1'b1;
    model_buf = d;
    chk("ready_after_load", FB'(tx_ready), '0);
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      if (i < FB) cap = {cap[FB-2:0], miso};
      else extra_or = extra_or | miso;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic spi_frame(input int nbits);
    model_start(nbits);
    cap = '0;
    extra_or = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(nbits);
    cs = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_full = 1'b0;
    model_seq = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_miso", FB'(miso), '0);
    chk("rst_miso_oe", FB'(miso_oe), '0);
    chk("rst_tx_ready", FB'(tx_ready), FB'(1));
    chk("rst_frame_done", FB'(frame_done), '0);
    chk("rst_underrun", FB'(underrun), '0);
    chk("rst_abort", FB'(abort), '0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [PW-1:0] d;
    int op;
    do_reset();
    repeat (GAP) @(negedge clk);

    load({16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234});
    spi_frame(FB);
`ifndef SPI_FRAME_HEADER_EN
    chk("directed_frame", cap, 64'h123456789ABCDEF0);
`endif
    chk("ready_after_frame", FB'(tx_ready), FB'(1));

    spi_frame(FB);

    load({$urandom, $urandom});
    spi_frame(20);
    chk("oe_after_abort", FB'(miso_oe), '0);
    spi_frame(FB);

    // reset at bit 30 with cs held low, a second frame already buffered
    load({$urandom, $urandom});
    model_start(FB);
    cap = '0;
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    load({$urandom, $urandom});
    spi_bits(30);
    do_reset();
    spi_bits(4);
    chk("no_start_after_rst", FB'(miso_oe), '0);
    cs = 1'b1;
    repeat (GAP) @(negedge clk);
    spi_frame(FB);

    // load lands on the same clk as the synchronised cs fall with an empty buffer
    d = {$urandom, $urandom};
    model_start(FB);
    cap = '0;
    @(negedge clk);
    cs = 1'b0;
    repeat (SYNC_STAGES) @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    model_full = 1'b1;
    model_buf = d;
    repeat (HALF - SYNC_STAGES - 1) @(negedge clk);
    spi_bits(FB);
    cs = 1'b1;
    repeat (GAP) @(negedge clk);
    chk("race_buffer_kept", FB'(tx_ready), '0);
    spi_frame(FB);

    load({$urandom, $urandom});
    spi_frame(FB + 3);
    chk("extra_bits_zero", FB'(extra_or), '0);

    for (int i = 0; i < 14; i++) begin
      op = $urandom_range(0, 3);
      if (op != 2) load({$urandom, $urandom});
      if (op == 3) spi_frame($urandom_range(1, FB - 1));
      else spi_frame(FB);
    end

`ifdef SPI_FRAME_HEADER_EN
    do_reset();
    repeat (GAP) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      load({$urandom, $urandom});
      spi_frame(FB);
      chk("header", FB'(cap[FB-1 -: 8]), FB'(8'hA0 + (i % 16)));
    end
`endif

    repeat (GAP) @(negedge clk);
    chk("queue_drained", FB'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
